clockworks: RTL and testbench



---
 rtl/clockworks_pkg.sv | 13 +
 rtl/clockworks_reset_stretch.sv | 52 +++++
 rtl/clockworks.sv | 43 ++++
 tb/tb_clockworks.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/clockworks_pkg.sv
// Shared constants for the board-level clock and reset generator.
package clockworks_pkg;

  // Board defaults: ~2^24 division of the oscillator and a 16-cycle reset stretch.
  localparam int unsigned SLOW_DEFAULT         = 24;
  localparam int unsigned RESET_CYCLES_DEFAULT = 16;

  // Width of a down-counter that must hold the value `cycles`.
  function automatic int unsigned stretch_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clockworks_reset_stretch.sv
// Push-button reset conditioning in the slow clock domain: two-flop
// synchronizer, stretch counter and a registered reset output.
module clockworks_reset_stretch
  import clockworks_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic button_i,
  output logic reset_o
);

  localparam int unsigned      CW       = stretch_width(RESET_CYCLES);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(RESET_CYCLES);

  // NOTE: this block creates the reset, so it cannot use one; power-up state
  // comes from declaration initializers, which become FPGA flop init values.
  logic          s0_q  = 1'b0;
  logic          s1_q  = 1'b0;
  logic [CW-1:0] cnt_q = CNT_LOAD;
  logic          r_q   = 1'b1;

  logic [CW-1:0] cnt_d;
  logic          r_d;

  // Stretch counter reloads while the synchronized button is held and
  // counts down to zero after release; reset is held while either is active.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the if/else can infer a latch.
    cnt_d = cnt_q;
    if (s1_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    r_d = s1_q | (cnt_q != '0);
  end

  // Synchronizer, counter and output register, all on the slow clock.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // s1_q must see the old s0_q for the synchronizer to have two stages.
    s0_q  <= button_i;
    s1_q  <= s0_q;
    cnt_q <= cnt_d;
    r_q   <= r_d;
  end

  assign reset_o = r_q;

endmodule

// File: rtl/clockworks.sv
// Board-level clock and reset generator: divides the oscillator CLK by
// 2^SLOW into the system clock and derives a clean, stretched reset from the
// RESET push-button, synchronous to the generated clock.
module clockworks
  import clockworks_pkg::*;
#(
  parameter int unsigned SLOW         = SLOW_DEFAULT,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic reset
);

  generate
    if (SLOW == 0) begin : g_passthrough
      assign clk = CLK;
    end else begin : g_divider
      // Never reset, so the system clock keeps running while reset is high.
      logic [SLOW-1:0] div_q = '0;
      logic [SLOW-1:0] div_d;

      // Free-running increment; wraps naturally at 2^SLOW.
      always_comb div_d = div_q + SLOW'(1);

      // Divider register on the board oscillator.
      always_ff @(posedge CLK) div_q <= div_d;

      // MSB gives a 50% duty clock with period 2^SLOW oscillator cycles.
      assign clk = div_q[SLOW-1];
    end
  endgenerate

  clockworks_reset_stretch #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset_stretch (
    .clk_i   (clk),
    .button_i(RESET),
    .reset_o (reset)
  );

endmodule

// File: tb/tb_clockworks.sv
// Bench for clockworks: one divided instance (SLOW=2) and one passthrough
// instance (SLOW=0) share the oscillator and push-button stimulus.
module tb_clockworks;

  localparam int N = 4;  // RESET_CYCLES

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic clk_2, reset_2;
  logic clk_0, reset_0;

  int  checks = 0;
  int  errors = 0;
  int  n_clk  = 0;   // oscillator rising edges so far
  int  k2     = 0;   // slow-clock rising edges so far (SLOW=2)
  int  k0     = 0;   // clock rising edges so far (SLOW=0)
  bit  hist2[$];     // button level seen at each slow-clock edge
  bit  hist0[$];
  bit  exp2   = 1'b1;
  bit  exp0   = 1'b1;
  longint first_rise = 0;
  longint last_rise  = 0;

  always #5 CLK = ~CLK;

  clockworks #(.SLOW(2), .RESET_CYCLES(N)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .clk  (clk_2),
    .reset(reset_2)
  );

  clockworks #(.SLOW(0), .RESET_CYCLES(N)) dut_pass (
    .CLK  (CLK),
    .RESET(RESET),
    .clk  (clk_0),
    .reset(reset_0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reset is high after edge k if power-up was within the last N edges, or
  // the button was seen high at any edge in [k-N-2, k-2]: two edges of
  // synchronizer delay, then N edges of stretch after the last high sample.
  function automatic bit model_reset(input int which, input int k);
    bit hi = (k <= N);
    for (int m = k - N - 2; m <= k - 2; m++) begin
      if (m >= 1) hi |= (which == 2) ? hist2[m-1] : hist0[m-1];
    end
    return hi;
  endfunction

  // Divider reference: after n oscillator edges the counter holds n mod 4.
  always @(posedge CLK) begin
    n_clk++;
    #1;
    check("clk_div_hi", clk_2, 32'((n_clk / 2) % 2));
    check("clk_pass_hi", clk_0, CLK);
  end

  always @(negedge CLK) begin
    #1;
    check("clk_div_lo", clk_2, 32'((n_clk / 2) % 2));
    check("clk_pass_lo", clk_0, CLK);
  end

  // Slow-domain reset and clock period checks.
  always @(posedge clk_2) begin
    hist2.push_back(RESET);
    k2++;
    if (k2 == 1) first_rise = $time;
    else check("clk_period", 32'($time - last_rise), 40);
    last_rise = $time;
    #1;
    exp2 = model_reset(2, k2);
    check("reset_slow", reset_2, exp2);
  end

  always @(negedge clk_2) check("reset_slow_hold", reset_2, exp2);

  // Passthrough-domain reset checks.
  always @(posedge clk_0) begin
    hist0.push_back(RESET);
    k0++;
    #1;
    exp0 = model_reset(0, k0);
    check("reset_pass", reset_0, exp0);
  end

  // Drive the button to `val` at the next oscillator falling edge and keep it
  // there for `cycles` oscillator periods.
  task automatic hold(input logic val, input int cycles);
    @(negedge CLK);
    RESET = val;
    repeat (cycles - 1) @(negedge CLK);
  endtask

  initial begin
    #1;
    check("reset_t0_slow", reset_2, 1);
    check("reset_t0_pass", reset_0, 1);
    check("clk_t0", clk_2, 0);

    // Power-up with button low: release, then 50 quiet slow edges.
    hold(1'b0, 220);

    // Press for 10 slow periods, release and let the stretch run out.
    hold(1'b1, 40);
    hold(1'b0, 60);

    // One-oscillator-period glitch placed between slow-clock edges.
    while (n_clk % 4 != 2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    hold(1'b0, 40);
    check("glitch_ignored", reset_2, 0);

    // Re-press two slow edges into the stretch, for three slow periods.
    hold(1'b1, 40);
    hold(1'b0, 8);
    hold(1'b1, 12);
    hold(1'b0, 60);

    // Random presses and gaps of arbitrary phase and length.
    repeat (20) begin
      hold(1'b1, int'($urandom_range(1, 50)));
      hold(1'b0, int'($urandom_range(1, 80)));
    end
    hold(1'b0, 60);

    check("first_rise", 32'(first_rise), 15);
    check("reset_end_slow", reset_2, 0);
    check("reset_end_pass", reset_0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
